// File: rtl/interp_pkg.sv
// interp_pkg: shared definitions for the interpolator segment selector.
//   FRAC_BITS : number of fraction bits in the signed fixed-point samples.
//   WIDTH_DEF : default sample width.
//   state_e   : controller states (IDLE, SCAN, LAUNCH, SETTLE, WAIT, DONE).
//   sample_t  : signed sample of the default width.
package interp_pkg;

  localparam int FRAC_BITS = 7;
  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    LAUNCH = 3'd2,
    SETTLE = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef logic signed [WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/interp_sample_table.sv
// interp_sample_table: DEPTH-entry register file of (T,U) sample pairs.
// Ports:
//   clk_i              : rising-edge clock (no reset; contents survive reset).
//   wr_en_i            : write strobe (caller gates it to idle periods).
//   wr_addr_i          : write address.
//   wr_t_i / wr_u_i    : sample time / value written at wr_addr_i.
//   rd_addr_i          : read address idx; entries idx and idx+1 are read.
//   t_lo_o / u_lo_o    : T[idx] / U[idx] (combinational).
//   t_hi_o / u_hi_o    : T[idx+1] / U[idx+1] (combinational).
module interp_sample_table #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_t_i,
  input  logic [WIDTH-1:0] wr_u_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] t_lo_o,
  output logic [WIDTH-1:0] u_lo_o,
  output logic [WIDTH-1:0] t_hi_o,
  output logic [WIDTH-1:0] u_hi_o
);

  logic [WIDTH-1:0] t_mem [DEPTH];
  logic [WIDTH-1:0] u_mem [DEPTH];
  logic [AW-1:0]    rd_addr_nx;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      t_mem[wr_addr_i] <= wr_t_i;
      u_mem[wr_addr_i] <= wr_u_i;
    end
  end

  // idx+1 never wraps in use: the scanner stops at idx == len-2.
  assign rd_addr_nx = rd_addr_i + AW'(1);

  assign t_lo_o = t_mem[rd_addr_i];
  assign u_lo_o = u_mem[rd_addr_i];
  assign t_hi_o = t_mem[rd_addr_nx];
  assign u_hi_o = u_mem[rd_addr_nx];

endmodule

// File: rtl/interp_segment_select.sv
// interp_segment_select: finds the table segment bracketing a query time Tk,
// feeds it to the interpolateALU and returns the ALU result to the caller.
// Optional feature macro: INTERP_SEG_EXTRAP_EN. When defined, an out-of-range
// Tk still launches the ALU on the end segment (linear extrapolation);
// otherwise it finishes immediately with err_out=1.
// Ports:
//   clk, rst            : clock, synchronous active-high reset.
//   wr_en/wr_addr/wr_t/wr_u : table write port, honoured only when idle.
//   tbl_len, start, Tk  : query request; tbl_len and Tk latched on accept.
//   busy, done          : busy while a query is in flight; done one-cycle pulse.
//   Uk_out, err_out, range_err : results, updated together with done.
//   alu_Tk..alu_Uz, alu_start : operands and start pulse to the ALU.
//   alu_Uk, alu_error, alu_ready : ALU result interface.
//   state_dbg           : current controller state (state_e encoding).
// Handshake: alu_start is high for exactly one cycle (LAUNCH) with operands
// valid; operands stay stable until the result is taken. alu_ready is only
// sampled in WAIT, one full cycle after alu_start, so a level left high by
// a previous operation cannot be mistaken for the new result.
module interp_segment_select
  import interp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_t,
  input  logic [WIDTH-1:0] wr_u,
  input  logic [AW:0]      tbl_len,
  input  logic             start,
  input  logic [WIDTH-1:0] Tk,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Uk_out,
  output logic             err_out,
  output logic             range_err,
  output logic [WIDTH-1:0] alu_Tk,
  output logic [WIDTH-1:0] alu_Tn,
  output logic [WIDTH-1:0] alu_Tz,
  output logic [WIDTH-1:0] alu_Un,
  output logic [WIDTH-1:0] alu_Uz,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_Uk,
  input  logic             alu_error,
  input  logic             alu_ready,
  output logic [2:0]       state_dbg
);

  state_e                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [AW:0]             len_q, len_d;
  logic signed [WIDTH-1:0] tk_q, tk_d;
  logic                    oor_q, oor_d;
  logic [WIDTH-1:0]        uk_q, uk_d;
  logic                    err_q, err_d;
  logic                    rng_q, rng_d;
  logic [WIDTH-1:0]        a_tk_q, a_tk_d, a_tn_q, a_tn_d, a_tz_q, a_tz_d;
  logic [WIDTH-1:0]        a_un_q, a_un_d, a_uz_q, a_uz_d;

  logic signed [WIDTH-1:0] t_lo, t_hi;
  logic [WIDTH-1:0]        u_lo, u_hi;
  logic                    last, oor, go_launch;

  interp_sample_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_table (
    .clk_i     (clk),
    .wr_en_i   (wr_en && (state_q == IDLE)),
    .wr_addr_i (wr_addr),
    .wr_t_i    (wr_t),
    .wr_u_i    (wr_u),
    .rd_addr_i (idx_q),
    .t_lo_o    (t_lo),
    .u_lo_o    (u_lo),
    .t_hi_o    (t_hi),
    .u_hi_o    (u_hi)
  );

  // Last segment reached; len >= 2 is guaranteed whenever SCAN is active.
  assign last = ({1'b0, idx_q} == (len_q - (AW+1)'(2)));
  // Below range can only be seen at idx 0 (scan exits there immediately);
  // above range can only be seen on the last segment.
  assign oor  = ((idx_q == '0) && (tk_q < t_lo)) || (last && (tk_q > t_hi));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tk_d      = tk_q;
    oor_d     = oor_q;
    uk_d      = uk_q;
    err_d     = err_q;
    rng_d     = rng_q;
    a_tk_d    = a_tk_q;
    a_tn_d    = a_tn_q;
    a_tz_d    = a_tz_q;
    a_un_d    = a_un_q;
    a_uz_d    = a_uz_q;
    go_launch = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tk_d  = Tk;
          len_d = tbl_len;
          idx_d = '0;
          if (tbl_len < (AW+1)'(2)) begin
            state_d = DONE;
            uk_d    = '0;
            err_d   = 1'b1;
            rng_d   = 1'b0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // An exact hit on T[idx+1] advances, so the segment found has Tn == Tk.
        if ((tk_q < t_hi) || last) begin
          oor_d = oor;
`ifdef INTERP_SEG_EXTRAP_EN
          go_launch = 1'b1;
`else
          if (oor) begin
            state_d = DONE;
            uk_d    = '0;
            err_d   = 1'b1;
            rng_d   = 1'b1;
          end else begin
            go_launch = 1'b1;
          end
`endif
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      LAUNCH: state_d = SETTLE;
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (alu_ready) begin
          state_d = DONE;
          uk_d    = alu_Uk;
          err_d   = alu_error;
          rng_d   = oor_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_launch) begin
      state_d = LAUNCH;
      a_tk_d  = tk_q;
      a_tn_d  = t_lo;
      a_tz_d  = t_hi;
      a_un_d  = u_lo;
      a_uz_d  = u_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      tk_q    <= '0;
      oor_q   <= 1'b0;
      uk_q    <= '0;
      err_q   <= 1'b0;
      rng_q   <= 1'b0;
      a_tk_q  <= '0;
      a_tn_q  <= '0;
      a_tz_q  <= '0;
      a_un_q  <= '0;
      a_uz_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tk_q    <= tk_d;
      oor_q   <= oor_d;
      uk_q    <= uk_d;
      err_q   <= err_d;
      rng_q   <= rng_d;
      a_tk_q  <= a_tk_d;
      a_tn_q  <= a_tn_d;
      a_tz_q  <= a_tz_d;
      a_un_q  <= a_un_d;
      a_uz_q  <= a_uz_d;
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign alu_start = (state_q == LAUNCH);
  assign Uk_out    = uk_q;
  assign err_out   = err_q;
  assign range_err = rng_q;
  assign alu_Tk    = a_tk_q;
  assign alu_Tn    = a_tn_q;
  assign alu_Tz    = a_tz_q;
  assign alu_Un    = a_un_q;
  assign alu_Uz    = a_uz_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_interp_segment_select.sv
// tb_interp_segment_select: directed bench for interp_segment_select.
// Table T={0,128,256,384}, U={0,256,256,640}; a behavioural ALU answers
// each alu_start. Timing is counted in cycles after the accepting edge
// (cycle 1 is the first cycle after start was sampled).
module tb_interp_segment_select;
  import interp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_t, wr_u;
  logic [4:0]  tbl_len;
  logic        start;
  logic [15:0] Tk;
  logic        busy, done, err_out, range_err, alu_start;
  logic [15:0] Uk_out, alu_Tk, alu_Tn, alu_Tz, alu_Un, alu_Uz;
  logic [15:0] alu_Uk;
  logic        alu_error, alu_ready;
  logic [2:0]  state_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  interp_segment_select dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_t(wr_t), .wr_u(wr_u),
    .tbl_len(tbl_len), .start(start), .Tk(Tk), .busy(busy), .done(done),
    .Uk_out(Uk_out), .err_out(err_out), .range_err(range_err),
    .alu_Tk(alu_Tk), .alu_Tn(alu_Tn), .alu_Tz(alu_Tz), .alu_Un(alu_Un), .alu_Uz(alu_Uz),
    .alu_start(alu_start), .alu_Uk(alu_Uk), .alu_error(alu_error), .alu_ready(alu_ready),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural interpolateALU: Uk = Un + (Uz-Un)*(Tk-Tn)/(Tz-Tn).
  function automatic void alu_model(input logic [15:0] tk, tn, tz, un, uz,
                                    output logic [15:0] uk, output logic err);
    int tki, tni, tzi, uni, uzi;
    tki = $signed(tk); tni = $signed(tn); tzi = $signed(tz);
    uni = $signed(un); uzi = $signed(uz);
    if (tzi == tni) begin
      err = 1'b1;
      uk  = 16'h0000;
    end else begin
      err = 1'b0;
      uk  = 16'(uni + (uzi - uni) * (tki - tni) / (tzi - tni));
    end
  endfunction

  task automatic write_entry(input logic [3:0] a, input logic [15:0] t, input logic [15:0] u);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_t = t; wr_u = u;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One query. stale: drive a bogus alu_ready through LAUNCH and SETTLE.
  // wr_busy: attempt a table write to entry 1 while the query is running.
  task automatic run_query(input string tag, input logic [15:0] tk, input logic [4:0] len,
                           input int exp_launch,
                           input logic [15:0] e_tn, input logic [15:0] e_tz,
                           input logic [15:0] e_un, input logic [15:0] e_uz,
                           input logic [15:0] e_uk, input logic e_err, input logic e_rng,
                           input int e_done_cyc, input bit stale, input bit wr_busy);
    int cyc, k, launches;
    logic [15:0] m_uk;
    logic m_err;
    @(negedge clk);
    Tk = tk; tbl_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0; Tk = 16'h5A5A; tbl_len = 5'd0;
    cyc = 1; k = -1; launches = 0; m_uk = '0; m_err = 1'b0;
    chk({tag, ".busy"}, busy, (len >= 5'd2));
    while (done !== 1'b1 && cyc < 60) begin
      if (wr_busy && cyc == 1) begin
        wr_en = 1'b1; wr_addr = 4'd1; wr_t = 16'h0500; wr_u = 16'h0123;
      end else begin
        wr_en = 1'b0;
      end
      if (alu_start === 1'b1) begin
        launches++;
        k = 0;
        if (exp_launch == 1) begin
          n_chk++;
          if (alu_Tk !== tk) begin
            n_fail++;
            $error("FAIL %s.alu_Tk observed=%0d expected=%0d", tag, alu_Tk, tk);
          end
          n_chk++;
          if (alu_Tn !== e_tn) begin
            n_fail++;
            $error("FAIL %s.alu_Tn observed=%0d expected=%0d", tag, alu_Tn, e_tn);
          end
          n_chk++;
          if (alu_Tz !== e_tz) begin
            n_fail++;
            $error("FAIL %s.alu_Tz observed=%0d expected=%0d", tag, alu_Tz, e_tz);
          end
          n_chk++;
          if (alu_Un !== e_un) begin
            n_fail++;
            $error("FAIL %s.alu_Un observed=%0d expected=%0d", tag, alu_Un, e_un);
          end
          n_chk++;
          if (alu_Uz !== e_uz) begin
            n_fail++;
            $error("FAIL %s.alu_Uz observed=%0d expected=%0d", tag, alu_Uz, e_uz);
          end
        end
        alu_model(alu_Tk, alu_Tn, alu_Tz, alu_Un, alu_Uz, m_uk, m_err);
      end
      if (k >= 0) begin
        case (k)
          0, 1: if (stale) begin alu_ready = 1'b1; alu_Uk = 16'h7777; alu_error = 1'b1; end
          2: alu_ready = 1'b0;
          3: begin alu_ready = 1'b1; alu_Uk = m_uk; alu_error = m_err; end
          default: ;
        endcase
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".done_cyc"}, cyc, e_done_cyc);
    chk({tag, ".launches"}, launches, exp_launch);
    chk({tag, ".busy_at_done"}, busy, 1'b0);
    chk({tag, ".Uk_out"}, Uk_out, e_uk);
    chk({tag, ".err_out"}, err_out, e_err);
    chk({tag, ".range_err"}, range_err, e_rng);
    @(negedge clk);
    alu_ready = 1'b0; alu_error = 1'b0; alu_Uk = 16'h0000;
    chk({tag, ".done_pulse"}, done, 1'b0);
    chk({tag, ".idle"}, state_dbg, 3'(IDLE));
    chk({tag, ".Uk_held"}, Uk_out, e_uk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_t = '0; wr_u = '0;
    tbl_len = '0; start = 1'b0; Tk = '0;
    alu_Uk = '0; alu_error = 1'b0; alu_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.state", state_dbg, 3'(IDLE));
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.alu_start", alu_start, 1'b0);
    chk("rst.Uk_out", Uk_out, 16'h0000);
    chk("rst.err_out", err_out, 1'b0);
    chk("rst.range_err", range_err, 1'b0);
    chk("rst.alu_Tz", alu_Tz, 16'h0000);
    rst = 1'b0;

    write_entry(4'd0, 16'd0,   16'd0);
    write_entry(4'd1, 16'd128, 16'd256);
    write_entry(4'd2, 16'd256, 16'd256);
    write_entry(4'd3, 16'd384, 16'd640);

    // seg 1, two scan cycles
    run_query("q192", 16'd192, 5'd4, 1, 16'd128, 16'd256, 16'd256, 16'd256,
              16'd256, 1'b0, 1'b0, 7, 1'b0, 1'b0);
    // seg 2, last segment, three scan cycles
    run_query("q320", 16'd320, 5'd4, 1, 16'd256, 16'd384, 16'd256, 16'd640,
              16'd448, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    // exact hit on T[1] advances; stale ready through LAUNCH/SETTLE is ignored
    run_query("q128_stale", 16'd128, 5'd4, 1, 16'd128, 16'd256, 16'd256, 16'd256,
              16'd256, 1'b0, 1'b0, 7, 1'b1, 1'b0);
`ifdef INTERP_SEG_EXTRAP_EN
    run_query("q512", 16'd512, 5'd4, 1, 16'd256, 16'd384, 16'd256, 16'd640,
              16'd1024, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    run_query("qneg64", 16'hFFC0, 5'd4, 1, 16'd0, 16'd128, 16'd0, 16'd256,
              16'hFF80, 1'b0, 1'b1, 6, 1'b0, 1'b0);
`else
    run_query("q512", 16'd512, 5'd4, 0, 16'd0, 16'd0, 16'd0, 16'd0,
              16'd0, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    run_query("qneg64", 16'hFFC0, 5'd4, 0, 16'd0, 16'd0, 16'd0, 16'd0,
              16'd0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
`endif
    // len < 2: immediate error, no ALU
    run_query("len1", 16'd0, 5'd1, 0, 16'd0, 16'd0, 16'd0, 16'd0,
              16'd0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    // write attempted while busy must not reach the table
    run_query("wr_busy", 16'd192, 5'd4, 1, 16'd128, 16'd256, 16'd256, 16'd256,
              16'd256, 1'b0, 1'b0, 7, 1'b0, 1'b1);
    run_query("after_wr", 16'd160, 5'd4, 1, 16'd128, 16'd256, 16'd256, 16'd256,
              16'd256, 1'b0, 1'b0, 7, 1'b0, 1'b0);

    // reset while waiting for the ALU
    @(negedge clk);
    Tk = 16'd320; tbl_len = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst.in_wait", state_dbg, 3'(WAIT));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst.state", state_dbg, 3'(IDLE));
    chk("mid_rst.busy", busy, 1'b0);
    chk("mid_rst.alu_start", alu_start, 1'b0);
    chk("mid_rst.Uk_out", Uk_out, 16'h0000);
    chk("mid_rst.alu_Uz", alu_Uz, 16'h0000);
    rst = 1'b0;
    run_query("post_rst", 16'd320, 5'd4, 1, 16'd256, 16'd384, 16'd256, 16'd640,
              16'd448, 1'b0, 1'b0, 8, 1'b0, 1'b0);

    // degenerate last segment T[1]=T[2]=128: ALU divide-by-zero propagates
    write_entry(4'd2, 16'd128, 16'd256);
    run_query("divzero", 16'd128, 5'd3, 1, 16'd128, 16'd128, 16'd256, 16'd256,
              16'd0, 1'b1, 1'b0, 7, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
